// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, program memory address, instruction FIFO.
// Branch redirect flushes the FIFO; halt freezes fetch while decode keeps draining.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] ram_addr,
  input  logic [15:0] ram_dout,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t             state;
  logic [15:0]        pc;
  logic [15:0]        fifo_data [DEPTH];
  logic [15:0]        fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               pop;
  logic               push;

  assign ram_addr    = pc;
  assign instr_valid = (state != S_EMPTY);
  assign pop         = instr_valid & instr_ready;
  assign push        = !redirect & !halt & ((count < FULL_CNT) | pop);

  // Head is gated by the valid flag so an empty FIFO never shows stale words.
  assign instr    = instr_valid ? fifo_data[rptr] : 16'h0000;
  assign instr_pc = instr_valid ? fifo_pc[rptr]   : 16'h0000;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      state <= S_EMPTY;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= 16'h0000;
        fifo_pc[i]   <= 16'h0000;
      end
    end else if (redirect) begin
      // Redirect wins over any pop or push in the same cycle.
      pc    <= redirect_pc;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      state <= S_EMPTY;
    end else begin
      if (push) begin
        fifo_data[wptr] <= ram_dout;
        fifo_pc[wptr]   <= pc;
        wptr            <= wptr + PTR_W'(1);
        pc              <= pc + 16'd1;
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      count <= count_next;
      if (count_next == '0) begin
        state <= S_EMPTY;
      end else if (count_next == FULL_CNT) begin
        state <= S_FULL;
      end else begin
        state <= S_FILLING;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt)
  );

  always #5 clk = ~clk;

  assign ram_dout = (ram_addr == 16'h0000) ? 16'ha861 :
                    (ram_addr == 16'h0001) ? 16'h8463 : 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] pc, input logic [15:0] word);
    exp_q.push_back({pc, word});
  endtask

  task automatic chk_drained(input string name);
    chk(name, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every accepted head is compared against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          fails++;
          $display("FAIL pop_word: got pc %h instr %h expected pc %h instr %h",
                   instr_pc, instr, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_addr", ram_addr, 16'h0000);

    // Streaming, one instruction per cycle
    do_reset();
    instr_ready = 1'b1;
    chk("s1_addr0", ram_addr, 16'h0000);
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    expect_word(16'h0002, 16'h0000);
    expect_word(16'h0003, 16'h0000);
    step();
    chk("s1_valid_e1", {15'd0, instr_valid}, 16'd1);
    chk("s1_addr1", ram_addr, 16'h0001);
    step();
    chk("s1_addr2", ram_addr, 16'h0002);
    step();
    chk("s1_addr3", ram_addr, 16'h0003);
    step();
    step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s1_drained");

    // Backpressure saturates at DEPTH, then drains without gaps
    do_reset();
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    expect_word(16'h0002, 16'h0000);
    repeat (5) step();
    chk("s2_addr_hold", ram_addr, 16'h0002);
    chk("s2_head_instr", instr, 16'ha861);
    chk("s2_head_pc", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    step();
    chk("s2_valid_e6", {15'd0, instr_valid}, 16'd1);
    chk("s2_head_e6", instr, 16'h8463);
    step();
    chk("s2_valid_e7", {15'd0, instr_valid}, 16'd1);
    chk("s2_head_pc_e7", instr_pc, 16'h0002);
    step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s2_drained");

    // Redirect with a full FIFO
    do_reset();
    step();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    chk("s3_valid_flush", {15'd0, instr_valid}, 16'd0);
    chk("s3_addr", ram_addr, 16'h0000);
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    step();
    chk("s3_valid_e2", {15'd0, instr_valid}, 16'd1);
    chk("s3_head_instr", instr, 16'ha861);
    chk("s3_head_pc", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    step();
    step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s3_drained");

    // PC wrap-around
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("s4_addr", ram_addr, 16'hFFFE);
    expect_word(16'hFFFE, 16'h0000);
    expect_word(16'hFFFF, 16'h0000);
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    instr_ready = 1'b1;
    repeat (5) step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s4_drained");

    // Halt drains the FIFO and freezes the PC
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    step();
    step();
    halt = 1'b1;
    instr_ready = 1'b1;
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    step();
    step();
    chk("s5_valid_empty", {15'd0, instr_valid}, 16'd0);
    chk("s5_addr_frozen", ram_addr, 16'h0002);
    step();
    chk("s5_addr_frozen2", ram_addr, 16'h0002);
    halt = 1'b0;
    expect_word(16'h0002, 16'h0000);
    expect_word(16'h0003, 16'h0000);
    step();
    chk("s5_addr_resume", ram_addr, 16'h0003);
    step();
    step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s5_drained");

    // Asynchronous reset between edges
    do_reset();
    instr_ready = 1'b1;
    expect_word(16'h0000, 16'ha861);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("s6_valid_async", {15'd0, instr_valid}, 16'd0);
    chk("s6_addr_async", ram_addr, 16'h0000);
    chk("s6_instr_async", instr, 16'h0000);
    chk_drained("s6_pre_drained");
    step();
    rst = 1'b0;
    expect_word(16'h0000, 16'ha861);
    expect_word(16'h0001, 16'h8463);
    step();
    step();
    step();
    instr_ready = 1'b0;
    #1;
    chk_drained("s6_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
